jtkcpu_divider: RTL

//  Multi-cycle restoring divider answering the ALU's divide request (start/busy/quot/rem/v).

---
 rtl/jtkcpu_divider.sv | 113 +++++++++++
 1 files changed

// File: rtl/jtkcpu_divider.sv
// Multi-cycle restoring divider: unsigned/signed 16/8 and 8/8 division, one quotient bit
// per enabled clock. Magnitudes are divided; signs are applied in the final FIX step.
module jtkcpu_divider #(
  parameter int unsigned W  = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cen_i,
  input  logic [W-1:0]  op0_i,
  input  logic [DW-1:0] op1_i,
  input  logic          len_i,
  input  logic          sign_i,
  input  logic          start_i,
  output logic [W-1:0]  quot_o,
  output logic [DW-1:0] rem_o,
  output logic          busy_o,
  output logic          v_o
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e        state_q;
  logic [W-1:0]  dvd_q;   // dividend magnitude shifting out MSB-first, quotient shifting in
  logic [DW-1:0] dvs_q;   // divisor magnitude
  logic [DW-1:0] pr_q;    // partial remainder
  logic [CW-1:0] cnt_q;
  logic          negq_q, negr_q, zero_q, ovf_q;

  logic [W-1:0]  dvd_sx, dvd_abs, dvd_load, quot_fix;
  logic [DW-1:0] dvs_abs, diff, pr_d, rem_fix;
  logic [DW:0]   pr_sh;
  logic          dvd_neg, dvs_neg, no_borrow, ovf;

  // Operand conditioning at start and one restoring step per RUN edge.
  always_comb begin
    dvd_sx    = len_i ? op0_i
                      : {{(W-DW){op0_i[DW-1] & sign_i}}, op0_i[DW-1:0]};
    dvd_neg   = sign_i & dvd_sx[W-1];
    dvd_abs   = dvd_neg ? -dvd_sx : dvd_sx;
    dvs_neg   = sign_i & op1_i[DW-1];
    dvs_abs   = dvs_neg ? -op1_i : op1_i;
    // 8-bit dividends are left-aligned so the same MSB-first shift serves both widths.
    dvd_load  = len_i ? dvd_abs : {dvd_abs[DW-1:0], {(W-DW){1'b0}}};
    ovf       = sign_i & len_i & (op0_i == {1'b1, {(W-1){1'b0}}}) & (op1_i == '1);
    pr_sh     = {pr_q, dvd_q[W-1]};
    no_borrow = pr_sh >= {1'b0, dvs_q};
    diff      = DW'(pr_sh - {1'b0, dvs_q});
    pr_d      = no_borrow ? diff : pr_sh[DW-1:0];
    quot_fix  = negq_q ? -dvd_q : dvd_q;
    rem_fix   = negr_q ? -pr_q : pr_q;
  end

  // Divider FSM with registered results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      quot_o  <= '0;
      rem_o   <= '0;
      busy_o  <= 1'b0;
      v_o     <= 1'b0;
    end else if (cen_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_o <= 1'b1;
            dvs_q  <= dvs_abs;
            pr_q   <= '0;
            cnt_q  <= len_i ? CW'(W - 1) : CW'(DW - 1);
            negq_q <= dvd_neg ^ dvs_neg;
            negr_q <= dvd_neg;
            ovf_q  <= ovf;
            zero_q <= (op1_i == '0);
            // On divide-by-zero keep the raw dividend: its low bits become the remainder.
            dvd_q   <= (op1_i == '0) ? dvd_sx : dvd_load;
            state_q <= (op1_i == '0) ? StFix : StRun;
          end
        end
        StRun: begin
          dvd_q <= {dvd_q[W-2:0], no_borrow};
          pr_q  <= pr_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
          if (zero_q) begin
            quot_o <= '1;
            rem_o  <= dvd_q[DW-1:0];
            v_o    <= 1'b1;
          end else begin
            quot_o <= quot_fix;
            rem_o  <= rem_fix;
            v_o    <= ovf_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
